conv_argmax_engine: RTL and testbench

Parametrised successor of the single-window convolution/argmax accelerator attached to the CPU's Rm/Rn operand bus. It stores an NCH×KSIZE weight bank written two bytes per command and collects KSIZE input samples per window. It then runs a sequential multiply-accumulate per output channel and reports the index and value of the largest channel sum. Additions over the previous generation:
- configurable kernel size, channel count and data width;
- optional ReLU;
- busy/done/error status;
- soft window clear.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/conv_mac.sv | 49 ++++
 rtl/conv_argmax_engine.sv | 172 +++++++++++++++++
 tb/tb_conv_argmax_engine.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution/argmax engine: command bit positions,
// FSM encoding and the accumulator-width helper.
package conv_pkg;

  localparam int unsigned CMD_W       = 16;
  localparam int unsigned CMD_IN      = 0;
  localparam int unsigned CMD_WEN_LSB = 1;
  localparam int unsigned CMD_WEN_MSB = 8;
  localparam int unsigned CMD_CLR     = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Width that holds KSIZE full-scale products without overflow, plus a sign bit.
  function automatic int unsigned accw(input int unsigned dw, input int unsigned ksize);
    return 2 * dw + int'($clog2(ksize)) + 1;
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Registered multiply-accumulate with restart, signed/unsigned operands and an
// optional ReLU on the combinational running sum.
module conv_mac #(
  parameter int unsigned DW     = 8,
  parameter int unsigned ACCW   = 21,
  parameter bit          SIGNED = 1'b1,
  parameter bit          RELU   = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [ACCW-1:0] sum_c,
  output logic [ACCW-1:0] act_c
);

  localparam int unsigned PW = 2 * DW;

  logic [PW-1:0]   ext_a;
  logic [PW-1:0]   ext_b;
  logic [PW-1:0]   prod;
  logic [ACCW-1:0] prod_ext;
  logic [ACCW-1:0] acc;

  // Extending both operands to the product width keeps the low PW bits exact
  // for two's complement as well as unsigned operands.
  always_comb begin
    if (SIGNED) begin
      ext_a    = {{DW{a[DW-1]}}, a};
      ext_b    = {{DW{b[DW-1]}}, b};
    end else begin
      ext_a    = {{DW{1'b0}}, a};
      ext_b    = {{DW{1'b0}}, b};
    end
    prod = ext_a * ext_b;
    if (SIGNED) prod_ext = {{(ACCW-PW){prod[PW-1]}}, prod};
    else        prod_ext = {{(ACCW-PW){1'b0}}, prod};
    sum_c = (clr ? '0 : acc) + prod_ext;
    act_c = (RELU && SIGNED && sum_c[ACCW-1]) ? '0 : sum_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     acc <= '0;
    else if (en) acc <= sum_c;
  end

endmodule

// File: rtl/conv_argmax_engine.sv
// Single-window convolution with argmax over output channels, driven by the
// Rm/Rn operand bus: weight RAM, window buffer, control FSM and result registers.
module conv_argmax_engine
  import conv_pkg::*;
#(
  parameter int unsigned KSIZE  = 9,
  parameter int unsigned NCH    = 9,
  parameter int unsigned DW     = 8,
  parameter bit          SIGNED = 1'b1,
  parameter bit          RELU   = 1'b0,
  localparam int unsigned ACCW  = accw(DW, KSIZE)
) (
  input  logic            clk_i,
  input  logic            rst,
  input  logic [15:0]     Rm,
  input  logic [15:0]     Rn,
  output logic [3:0]      max_index,
  output logic [ACCW-1:0] max_value,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  localparam int unsigned NW = NCH * KSIZE;
  localparam int unsigned AW = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned TW = (KSIZE > 1) ? $clog2(KSIZE) : 1;

  logic          cmd_in;
  logic [7:0]    cmd_wen;
  logic          cmd_clr;
  logic          unused_cmd;

  assign cmd_in     = Rn[CMD_IN];
  assign cmd_wen    = Rn[CMD_WEN_MSB:CMD_WEN_LSB];
  assign cmd_clr    = Rn[CMD_CLR];
  assign unused_cmd = ^{Rn[CMD_CLR-1:CMD_WEN_MSB+1], Rm};

  logic [DW-1:0] wmem   [NW];
  logic [DW-1:0] window [KSIZE];

  state_t          state, state_nxt;
  logic [TW-1:0]   cnt;
  logic [TW-1:0]   tap;
  logic [3:0]      ch;
  logic [AW-1:0]   maddr;
  logic [3:0]      best_idx;
  logic [ACCW-1:0] best_val;

  logic smp_acc, wr_req, drop, mac_en, fin, last_tap, last_ch, better;
  logic [8:0] wa0, wa1;
  logic [ACCW-1:0] sum_c, act_c;

  assign last_tap = (tap == TW'(KSIZE - 1));
  assign last_ch  = (ch == 4'(NCH - 1));
  assign wa0      = {cmd_wen - 8'd1, 1'b0};
  assign wa1      = {cmd_wen - 8'd1, 1'b1};

  // Command decode and next state; CLR outranks IN, which outranks Wen.
  always_comb begin
    state_nxt = state;
    smp_acc   = 1'b0;
    wr_req    = 1'b0;
    drop      = 1'b0;
    mac_en    = 1'b0;
    fin       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!cmd_clr) begin
          if (cmd_in) begin
            smp_acc = 1'b1;
            if (cnt == TW'(KSIZE - 1)) state_nxt = ST_MAC;
          end else if (cmd_wen != 8'd0) begin
            wr_req = 1'b1;
          end
        end
      end
      ST_MAC: begin
        if (cmd_clr) begin
          state_nxt = ST_IDLE;
        end else begin
          mac_en = 1'b1;
          drop   = cmd_in || (cmd_wen != 8'd0);
          if (last_tap && last_ch) state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        fin       = 1'b1;
        drop      = !cmd_clr && (cmd_in || (cmd_wen != 8'd0));
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  conv_mac #(
    .DW    (DW),
    .ACCW  (ACCW),
    .SIGNED(SIGNED),
    .RELU  (RELU)
  ) u_mac (
    .clk  (clk_i),
    .rst  (rst),
    .en   (mac_en),
    .clr  (tap == '0),
    .a    (window[tap]),
    .b    (wmem[maddr]),
    .sum_c(sum_c),
    .act_c(act_c)
  );

  always_comb begin
    if (SIGNED) better = $signed(act_c) > $signed(best_val);
    else        better = act_c > best_val;
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Counters, running best, results and status.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      tap       <= '0;
      ch        <= '0;
      maddr     <= '0;
      best_idx  <= '0;
      best_val  <= '0;
      max_index <= '0;
      max_value <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      if (cmd_clr)      cnt <= '0;
      else if (smp_acc) cnt <= (cnt == TW'(KSIZE - 1)) ? '0 : cnt + TW'(1);

      if (mac_en) begin
        tap   <= last_tap ? '0 : tap + TW'(1);
        ch    <= last_tap ? (last_ch ? '0 : ch + 4'd1) : ch;
        maddr <= (last_tap && last_ch) ? '0 : maddr + AW'(1);
        if (last_tap && (ch == 4'd0 || better)) begin
          best_idx <= ch;
          best_val <= act_c;
        end
      end else begin
        tap   <= '0;
        ch    <= '0;
        maddr <= '0;
      end

      if (fin) begin
        max_index <= best_idx;
        max_value <= best_val;
      end
      busy_o <= (state_nxt != ST_IDLE);
      done_o <= fin;
      err_o  <= err_o | drop;
    end
  end

  // Storage arrays carry no reset; weights survive rst.
  always_ff @(posedge clk_i) begin
    if (smp_acc) window[cnt] <= Rm[DW-1:0];
    if (wr_req) begin
      if (32'(wa0) < NW) wmem[AW'(wa0)] <= Rm[DW-1:0];
      if (32'(wa1) < NW) wmem[AW'(wa1)] <= Rm[8+DW-1:8];
    end
  end

endmodule

// File: tb/tb_conv_argmax_engine.sv
// Directed bench for conv_argmax_engine: a default instance and a ReLU instance
// share the operand bus; results are compared against hand-computed vectors.
module tb_conv_argmax_engine;

  localparam int ACCW = 21;

  logic            clk;
  logic            rst;
  logic [15:0]     Rm;
  logic [15:0]     Rn;
  logic [3:0]      max_index, max_index_r;
  logic [ACCW-1:0] max_value, max_value_r;
  logic            busy_o, busy_r, done_o, done_r, err_o, err_r;

  int checks   = 0;
  int failures = 0;

  conv_argmax_engine u_dut (
    .clk_i(clk), .rst(rst), .Rm(Rm), .Rn(Rn),
    .max_index(max_index), .max_value(max_value),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  conv_argmax_engine #(.RELU(1'b1)) u_relu (
    .clk_i(clk), .rst(rst), .Rm(Rm), .Rn(Rn),
    .max_index(max_index_r), .max_value(max_value_r),
    .busy_o(busy_r), .done_o(done_r), .err_o(err_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0][7:0] w;
    logic [7:0]      s;
    int              idx;
    int              val;
    int              idx_r;
    int              val_r;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_val(input string name, input logic [ACCW-1:0] act, input int exp);
    logic [ACCW-1:0] e;
    e = ACCW'(exp);
    chk(name, 32'(act), 32'(e));
  endtask

  // Weight index = ch*9 + tap; each write carries two consecutive weights.
  task automatic write_weights(input logic [8:0][7:0] w);
    for (int k = 1; k <= 41; k++) begin
      int a;
      logic [7:0] lo, hi;
      a  = 2 * (k - 1);
      lo = w[4'(a / 9)];
      hi = (a + 1 < 81) ? w[4'((a + 1) / 9)] : 8'h00;
      Rm = {hi, lo};
      Rn = 16'(k << 1);
      tick();
    end
    Rn = 16'h0000;
  endtask

  task automatic feed(input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      Rn = 16'h0001;
      Rm = {8'h00, s};
      tick();
    end
    Rn = 16'h0000;
  endtask

  // Waits (bounded) for done_o, counting cycles from the edge that took sample KSIZE.
  task automatic expect_result(input string tag, input int start, input int ei, input int ev,
                               input int eir, input int evr);
    int n;
    n = start;
    while (done_o !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'd82);
    chk({tag, " relu done"}, 32'(done_r), 32'd1);
    chk({tag, " index"}, 32'(max_index), 32'(ei));
    chk_val({tag, " value"}, max_value, ev);
    chk({tag, " relu index"}, 32'(max_index_r), 32'(eir));
    chk_val({tag, " relu value"}, max_value_r, evr);
    tick();
    chk({tag, " busy after"}, 32'(busy_o), 32'd0);
    chk({tag, " done pulse"}, 32'(done_o), 32'd0);
  endtask

  initial begin
    logic [8:0][7:0] w_inc, w_off;
    int dones;

    for (int c = 0; c < 9; c++) begin
      w_inc[c] = 8'(c + 1);
      w_off[c] = 8'(c - 4);
    end
    vecs[0] = '{w: w_inc,     s: 8'd1,   idx: 8, val: 81,  idx_r: 8, val_r: 81};
    vecs[1] = '{w: '0,        s: 8'd5,   idx: 0, val: 0,   idx_r: 0, val_r: 0};
    vecs[2] = '{w: '1,        s: 8'd3,   idx: 3, val: 54,  idx_r: 3, val_r: 54};
    vecs[2].w[3] = 8'd2;
    vecs[3] = '{w: '1,        s: 8'd3,   idx: 0, val: -27, idx_r: 0, val_r: 0};
    vecs[4] = '{w: w_inc,     s: 8'hFE,  idx: 0, val: -18, idx_r: 0, val_r: 0};
    vecs[5] = '{w: w_off,     s: 8'd2,   idx: 8, val: 72,  idx_r: 8, val_r: 72};

    rst = 1'b1;
    Rm  = 16'h0000;
    Rn  = 16'h0000;
    tick();
    tick();
    chk("reset index", 32'(max_index), 32'd0);
    chk_val("reset value", max_value, 0);
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset done", 32'(done_o), 32'd0);
    chk("reset err", 32'(err_o), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      write_weights(vecs[i].w);
      feed(vecs[i].s, 9);
      chk($sformatf("v%0d busy start", i), 32'(busy_o), 32'd1);
      expect_result($sformatf("v%0d", i), 0, vecs[i].idx, vecs[i].val,
                    vecs[i].idx_r, vecs[i].val_r);
      chk($sformatf("v%0d err", i), 32'(err_o), 32'd0);
    end

    // Abort at MAC step 20: outputs hold the previous window, no done pulse.
    feed(8'd1, 9);
    repeat (20) tick();
    Rn = 16'h8000;
    tick();
    Rn = 16'h0000;
    chk("abort busy", 32'(busy_o), 32'd0);
    chk("abort index held", 32'(max_index), 32'd8);
    chk_val("abort value held", max_value, 72);
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      if (done_o) dones++;
      tick();
    end
    chk("abort no done", 32'(dones), 32'd0);
    feed(8'd1, 9);
    expect_result("after abort", 0, 8, 36, 8, 36);

    // CLR together with the last sample discards the window.
    feed(8'd50, 8);
    Rn = 16'h8001;
    Rm = 16'h0032;
    tick();
    Rn = 16'h0000;
    chk("clr last sample busy", 32'(busy_o), 32'd0);
    tick();
    chk("clr last sample idle", 32'(busy_o), 32'd0);
    feed(8'd1, 9);
    expect_result("after clr window", 0, 8, 36, 8, 36);

    // Reset mid-MAC clears outputs at once; weights survive.
    feed(8'd1, 9);
    repeat (10) tick();
    rst = 1'b1;
    #1;
    chk("midrst index", 32'(max_index), 32'd0);
    chk_val("midrst value", max_value, 0);
    chk("midrst busy", 32'(busy_o), 32'd0);
    chk("midrst done", 32'(done_o), 32'd0);
    chk("midrst err", 32'(err_o), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    feed(8'd1, 9);
    expect_result("after rst", 0, 8, 36, 8, 36);

    // Out-of-range writes are ignored; a tenth sample is dropped and flags err.
    write_weights(w_inc);
    Rm = 16'h8080;
    Rn = 16'(50 << 1);
    tick();
    Rn = 16'(233 << 1);
    tick();
    Rn = 16'h0000;
    chk("oob write err", 32'(err_o), 32'd0);
    feed(8'd1, 9);
    Rn = 16'h0001;
    Rm = 16'h0064;
    tick();
    Rn = 16'h0000;
    expect_result("ten samples", 1, 8, 81, 8, 81);
    chk("ten samples err", 32'(err_o), 32'd1);
    chk("ten samples relu err", 32'(err_r), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
